sprite_palette_engine: RTL and testbench
========================================

# sprite_palette_engine

Parametrised, runtime-writable sprite colour palette with multiple banks and a frame-synchronous fade engine. Sits between the sprite ROM index output and the VGA colour mux: takes a pixel palette index plus bank select and returns a registered RGB triple, a transparency flag and a valid strobe. Reset contents reproduce the team's standard sprite palette, so existing sprites render unchanged until software rewrites entries.

## Interface
- IDX_W, 4, palette index width; entries per bank = 2^IDX_W
- BANKS, 4, number of palette banks (power of two, ≥2)
- CH_W, 4, bits per colour channel
- Clk  in  1  system clock; one clock for the whole block
- Reset  in  1  synchronous, active-high reset
- pix_valid_in  in  1  pixel lookup request this cycle
- pix_bank  in  $clog2(BANKS)  bank for lookup
- pix_index  in  IDX_W  palette index for lookup
- pix_valid_out  out  1  output triple valid
- red, green, blue  out  CH_W each  faded colour
- transparent  out  1  looked-up index was 0 (colour key)
- wr_en  in  1  palette write strobe
- wr_bank  in  $clog2(BANKS)  bank to write
- wr_index  in  IDX_W  entry to write
- wr_data  in  3*CH_W  {R,G,B}
- frame_tick  in  1  one-cycle pulse per video frame
- fade_start  in  1  start fade (honoured only in IDLE)
- fade_dir  in  1  0 = fade to black, 1 = fade to full
- fade_step_frames  in  8  frames per level step; 0 treated as 1
- fade_busy  out  1  fade FSM not IDLE
- fade_level  out  CH_W+1  current brightness, 0..2^CH_W

## Operation
- Reset: every entry of every bank loads defaults: index 0 = {6,D,F} scaled to CH_W (top bits), index 1 = all zero, all others = all ones. fade_level = 2^CH_W, FSM IDLE, pix_valid_out = 0, red/green/blue = 0, transparent = 0, fade_busy = 0.
- Writes: wr_en updates entry next edge. Write and lookup of same bank/index in same cycle: lookup returns the old value (read-before-write). wr_en during Reset ignored.
- Lookup pipeline: stage 1 reads entry, captures valid and index==0; stage 2 scales each channel: out = (c × fade_level) >> CH_W, full-precision product (2·CH_W+1 bits) before shift. fade_level = 2^CH_W gives identity; 0 gives black.
- transparent is independent of fade and of entry contents.
- Outputs hold last values when pix_valid_in is low; only pix_valid_out drops.
- Fade FSM states IDLE, FADE_OUT, FADE_IN:
  - IDLE + fade_start: dir 0 → FADE_OUT, dir 1 → FADE_IN; frame counter cleared; fade_step_frames latched.
  - fading + frame_tick: counter increments; when counter reaches step−1, level ±1 and counter clears.
  - FADE_OUT exits to IDLE in the cycle level becomes 0; FADE_IN when level becomes 2^CH_W.
  - Start toward the level already held (e.g. fade out at 0): enter state, exit on first step event without changing level.
  - fade_start while busy ignored; level never wraps.
- Reset mid-fade: immediate return to IDLE, full level, default palette.

## Timing
- Lookup latency 2 cycles: pix_valid_in at edge n → pix_valid_out, colour, transparent valid after edge n+2; fully pipelined, one lookup per cycle.
- Write visible to lookups issued the cycle after wr_en.
- fade_level change takes effect on stage 2 the cycle after it updates; a pixel in flight uses the level present at its stage 2 edge.
- fade_busy asserts the cycle after fade_start, deasserts the cycle after the final step.
- Full fade at step S takes 2^CH_W × S frame_ticks.

## Structure
- Package sprite_palette_pkg: fade_state_t enum (IDLE, FADE_OUT, FADE_IN), default colour constants (KEY_RGB = 12'h6DF, BLACK, WHITE), channel-scaling function.
- Sub-module palette_ram: BANKS × 2^IDX_W × 3·CH_W storage, one sync write port, one registered read port, synchronous reset-to-default.
- Top holds fade FSM, frame counter, scaling stage.

## Test plan
- Reset, lookup bank 2 indices 0,1,5 → {6,D,F} transparent=1; {0,0,0}; {F,F,F}, each 2 cycles after request.
- Write bank 1 idx 3 = {A,5,2} while looking up same entry same cycle → old {F,F,F}; next-cycle lookup → {A,5,2}; bank 0 idx 3 unchanged.
- fade_dir=0, step=2: level 16→15 after 2 ticks; after 32 ticks level 0, fade_busy low, idx 2 reads {0,0,0}, idx 0 still transparent=1.
- Level 8 (mid-fade) on {F,7,1} → {7,3,0}; fade_start while busy ignored.
- step=0 fade in from 0 → +1 per tick, IDLE after 16 ticks; fade out at level 0 → busy one step, level stays 0.
- Reset asserted mid-fade after writes → level 16, IDLE, defaults restored, pix_valid_out 0 next cycle.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// Shared types, default palette colours and colour-scaling helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   fade_state_t            fade FSM state encoding
//   KEY_RGB / BLACK / WHITE 12-bit {R,G,B} reference colours, 4 bits per channel
//   nibble_to_chan          rescale a 4-bit reference channel to ch_w bits (top-aligned)
//   default_rgb             pack a 12-bit reference colour into a 3*ch_w word
//   scale_channel           (c * level) >> ch_w with a full-width product
package sprite_palette_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    localparam logic [11:0] KEY_RGB = 12'h6DF;
    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] WHITE   = 12'hFFF;

    // Reference colours are 4 bits per channel; wider channels keep the
    // nibble in their top bits, narrower channels keep the nibble's top bits.
    function automatic logic [31:0] nibble_to_chan(input logic [3:0] n, input int ch_w);
        logic [31:0] wide;
        wide = {28'd0, n};
        if (ch_w >= 4)
            return wide << (ch_w - 4);
        else
            return wide >> (4 - ch_w);
    endfunction

    function automatic logic [31:0] default_rgb(input logic [11:0] rgb12, input int ch_w);
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
        r = nibble_to_chan(rgb12[11:8], ch_w);
        g = nibble_to_chan(rgb12[7:4], ch_w);
        b = nibble_to_chan(rgb12[3:0], ch_w);
        return (r << (2 * ch_w)) | (g << ch_w) | b;
    endfunction

    // Level 2^ch_w is unity gain, so the product needs 2*ch_w+1 bits before
    // the shift; a 64-bit product covers every legal channel width.
    function automatic logic [31:0] scale_channel(input logic [31:0] c,
                                                  input logic [31:0] level,
                                                  input int          ch_w);
        logic [63:0] prod;
        logic [63:0] shifted;
        prod    = 64'(c) * 64'(level);
        shifted = prod >> ch_w;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Banked palette storage: BANKS x 2^IDX_W entries of {R,G,B}, reset to the standard sprite palette.
// Latency: 1 cycle read (registered read port); writes land at the next edge, reads see the old value.
// Backpressure: none; one read and one write may be accepted every cycle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset (reloads defaults)
//   wr_en, wr_bank, wr_index, wr_data write port, {R,G,B}
//   rd_en, rd_bank, rd_index         read request; rd_data holds while rd_en is low
//   rd_data                          registered read result
module palette_ram
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int BANKS = 4,
    parameter int CH_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(BANKS)-1:0] wr_bank,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [3*CH_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(BANKS)-1:0] rd_bank,
    input  logic [IDX_W-1:0]         rd_index,
    output logic [3*CH_W-1:0]        rd_data
);

    localparam int DW    = 3 * CH_W;
    localparam int AW    = $clog2(BANKS) + IDX_W;
    localparam int DEPTH = BANKS * (2 ** IDX_W);

    localparam logic [DW-1:0] KEY_DEF   = DW'(default_rgb(KEY_RGB, CH_W));
    localparam logic [DW-1:0] BLACK_DEF = DW'(default_rgb(BLACK, CH_W));
    localparam logic [DW-1:0] WHITE_DEF = DW'(default_rgb(WHITE, CH_W));

    logic [DW-1:0] mem [DEPTH];

    // Flat address is {bank, index}, so the low IDX_W bits of a flat
    // position are its index within the bank.
    function automatic logic [DW-1:0] entry_default(input int pos);
        logic [IDX_W-1:0] ent;
        ent = IDX_W'(pos);
        if (ent == '0)
            return KEY_DEF;
        else if (ent == IDX_W'(1))
            return BLACK_DEF;
        else
            return WHITE_DEF;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= entry_default(i);
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[AW'({wr_bank, wr_index})] <= wr_data;
            end
            // Non-blocking update of mem means a same-address read this
            // cycle returns the pre-write contents.
            if (rd_en) begin
                rd_data <= mem[AW'({rd_bank, rd_index})];
            end
        end
    end

endmodule

// File: rtl/sprite_palette_engine.sv
// Sprite palette lookup with per-frame fade: index+bank in, faded RGB + colour-key flag out.
// Latency: 2 cycles request-to-output (palette read, then fade scaling); one lookup per cycle.
// Backpressure: none; outputs hold their last value while no lookup is in flight.
//
// Ports:
//   clk, reset                               clock, synchronous active-high reset
//   pix_valid_in, pix_bank, pix_index        lookup request
//   pix_valid_out, red, green, blue          faded colour, registered
//   transparent                              looked-up index was 0
//   wr_en, wr_bank, wr_index, wr_data        palette write, {R,G,B}
//   frame_tick                               one pulse per video frame
//   fade_start, fade_dir, fade_step_frames   fade control (start honoured only when idle)
//   fade_busy, fade_level                    fade status, level 0..2^CH_W
module sprite_palette_engine
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int BANKS = 4,
    parameter int CH_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_valid_in,
    input  logic [$clog2(BANKS)-1:0] pix_bank,
    input  logic [IDX_W-1:0]         pix_index,
    output logic                     pix_valid_out,
    output logic [CH_W-1:0]          red,
    output logic [CH_W-1:0]          green,
    output logic [CH_W-1:0]          blue,
    output logic                     transparent,
    input  logic                     wr_en,
    input  logic [$clog2(BANKS)-1:0] wr_bank,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [3*CH_W-1:0]        wr_data,
    input  logic                     frame_tick,
    input  logic                     fade_start,
    input  logic                     fade_dir,
    input  logic [7:0]               fade_step_frames,
    output logic                     fade_busy,
    output logic [CH_W:0]            fade_level
);

    localparam logic [CH_W:0] LEVEL_FULL = {1'b1, {CH_W{1'b0}}};
    localparam logic [CH_W:0] LEVEL_ZERO = '0;
    localparam logic [CH_W:0] LEVEL_ONE  = {{CH_W{1'b0}}, 1'b1};

    // ---------------------------------------------------------------
    // Stage 1: palette read plus the request's valid and colour-key flag
    // ---------------------------------------------------------------
    logic [3*CH_W-1:0] s1_rgb;
    logic              s1_vld;
    logic              s1_key;

    palette_ram #(
        .IDX_W (IDX_W),
        .BANKS (BANKS),
        .CH_W  (CH_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .rd_en    (pix_valid_in),
        .rd_bank  (pix_bank),
        .rd_index (pix_index),
        .rd_data  (s1_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_key <= 1'b0;
        end else begin
            s1_vld <= pix_valid_in;
            // Colour key comes from the index alone, never from entry contents.
            if (pix_valid_in) begin
                s1_key <= (pix_index == '0);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: scale by the level current at this edge
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid_out <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            transparent   <= 1'b0;
        end else begin
            pix_valid_out <= s1_vld;
            if (s1_vld) begin
                red   <= CH_W'(scale_channel(32'(s1_rgb[2*CH_W +: CH_W]), 32'(fade_level), CH_W));
                green <= CH_W'(scale_channel(32'(s1_rgb[CH_W +: CH_W]), 32'(fade_level), CH_W));
                blue  <= CH_W'(scale_channel(32'(s1_rgb[0 +: CH_W]), 32'(fade_level), CH_W));
                transparent <= s1_key;
            end
        end
    end

    // ---------------------------------------------------------------
    // Fade FSM: one level step every step_q frame ticks
    // ---------------------------------------------------------------
    fade_state_t state;
    logic [7:0]  frame_cnt;
    logic [7:0]  step_q;
    logic        step_due;

    // A step event is the tick that completes step_q frames.
    assign step_due  = frame_tick && (frame_cnt == step_q - 8'd1);
    assign fade_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fade_level <= LEVEL_FULL;
            frame_cnt  <= 8'd0;
            step_q     <= 8'd1;
        end else begin
            case (state)
                IDLE: begin
                    if (fade_start) begin
                        state     <= fade_dir ? FADE_IN : FADE_OUT;
                        frame_cnt <= 8'd0;
                        step_q    <= (fade_step_frames == 8'd0) ? 8'd1 : fade_step_frames;
                    end
                end
                FADE_OUT: begin
                    if (step_due) begin
                        frame_cnt <= 8'd0;
                        // Already black: leave on this step without moving the level.
                        if (fade_level == LEVEL_ZERO) begin
                            state <= IDLE;
                        end else begin
                            fade_level <= fade_level - LEVEL_ONE;
                            if (fade_level == LEVEL_ONE) begin
                                state <= IDLE;
                            end
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                FADE_IN: begin
                    if (step_due) begin
                        frame_cnt <= 8'd0;
                        if (fade_level == LEVEL_FULL) begin
                            state <= IDLE;
                        end else begin
                            fade_level <= fade_level + LEVEL_ONE;
                            if (fade_level == LEVEL_FULL - LEVEL_ONE) begin
                                state <= IDLE;
                            end
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed self-checking bench for sprite_palette_engine (IDX_W=4, BANKS=4, CH_W=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_sprite_palette_engine;

    logic        clk;
    logic        reset;
    logic        pix_valid_in;
    logic [1:0]  pix_bank;
    logic [3:0]  pix_index;
    logic        pix_valid_out;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_data;
    logic        frame_tick;
    logic        fade_start;
    logic        fade_dir;
    logic [7:0]  fade_step_frames;
    logic        fade_busy;
    logic [4:0]  fade_level;

    int tests;
    int fails;

    sprite_palette_engine #(
        .IDX_W (4),
        .BANKS (4),
        .CH_W  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pix_valid_in     (pix_valid_in),
        .pix_bank         (pix_bank),
        .pix_index        (pix_index),
        .pix_valid_out    (pix_valid_out),
        .red              (red),
        .green            (green),
        .blue             (blue),
        .transparent      (transparent),
        .wr_en            (wr_en),
        .wr_bank          (wr_bank),
        .wr_index         (wr_index),
        .wr_data          (wr_data),
        .frame_tick       (frame_tick),
        .fade_start       (fade_start),
        .fade_dir         (fade_dir),
        .fade_step_frames (fade_step_frames),
        .fade_busy        (fade_busy),
        .fade_level       (fade_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one lookup and check the result two edges later.
    task automatic lookup(input string tag, input logic [1:0] bank, input logic [3:0] idx,
                          input logic [11:0] exp_rgb, input logic exp_t);
        pix_valid_in = 1'b1;
        pix_bank     = bank;
        pix_index    = idx;
        tick();
        pix_valid_in = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(pix_valid_out), 32'd1);
        chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
        chk({tag, "_t"}, 32'(transparent), 32'(exp_t));
    endtask

    task automatic wr(input logic [1:0] bank, input logic [3:0] idx, input logic [11:0] dat);
        wr_en    = 1'b1;
        wr_bank  = bank;
        wr_index = idx;
        wr_data  = dat;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic ftick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic start_fade(input logic dir, input logic [7:0] step);
        fade_start       = 1'b1;
        fade_dir         = dir;
        fade_step_frames = step;
        tick();
        fade_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        pix_valid_in = 1'b0;
        pix_bank = '0;
        pix_index = '0;
        wr_en = 1'b0;
        wr_bank = '0;
        wr_index = '0;
        wr_data = '0;
        frame_tick = 1'b0;
        fade_start = 1'b0;
        fade_dir = 1'b0;
        fade_step_frames = 8'd0;
        tick();
        tick();

        // Reset state
        chk("rst_level", 32'(fade_level), 32'd16);
        chk("rst_busy", 32'(fade_busy), 32'd0);
        chk("rst_vld", 32'(pix_valid_out), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'h000);
        chk("rst_t", 32'(transparent), 32'd0);
        reset = 1'b0;
        tick();

        // Back-to-back lookups, bank 2 indices 0, 1, 5
        pix_valid_in = 1'b1;
        pix_bank     = 2'd2;
        pix_index    = 4'd0;
        tick();
        chk("pipe_lat1_vld", 32'(pix_valid_out), 32'd0);
        pix_index = 4'd1;
        tick();
        chk("pipe0_vld", 32'(pix_valid_out), 32'd1);
        chk("pipe0_rgb", 32'({red, green, blue}), 32'h6DF);
        chk("pipe0_t", 32'(transparent), 32'd1);
        pix_index = 4'd5;
        tick();
        chk("pipe1_rgb", 32'({red, green, blue}), 32'h000);
        chk("pipe1_t", 32'(transparent), 32'd0);
        pix_valid_in = 1'b0;
        tick();
        chk("pipe5_vld", 32'(pix_valid_out), 32'd1);
        chk("pipe5_rgb", 32'({red, green, blue}), 32'hFFF);
        tick();
        chk("hold_vld", 32'(pix_valid_out), 32'd0);
        chk("hold_rgb", 32'({red, green, blue}), 32'hFFF);

        // Same-cycle write and lookup of bank 1 index 3: old value returned
        wr_en        = 1'b1;
        wr_bank      = 2'd1;
        wr_index     = 4'd3;
        wr_data      = 12'hA52;
        pix_valid_in = 1'b1;
        pix_bank     = 2'd1;
        pix_index    = 4'd3;
        tick();
        wr_en        = 1'b0;
        pix_valid_in = 1'b0;
        tick();
        chk("rbw_old_rgb", 32'({red, green, blue}), 32'hFFF);
        lookup("rbw_new", 2'd1, 4'd3, 12'hA52, 1'b0);
        lookup("other_bank", 2'd0, 4'd3, 12'hFFF, 1'b0);

        // Entry used for the mid-fade scaling check
        wr(2'd3, 4'd7, 12'hF71);
        lookup("f71_full", 2'd3, 4'd7, 12'hF71, 1'b0);

        // Fade out, step 2
        start_fade(1'b0, 8'd2);
        chk("fo_busy", 32'(fade_busy), 32'd1);
        chk("fo_level0", 32'(fade_level), 32'd16);
        ftick(1);
        chk("fo_level1t", 32'(fade_level), 32'd16);
        ftick(1);
        chk("fo_level2t", 32'(fade_level), 32'd15);
        ftick(14);
        chk("fo_level16t", 32'(fade_level), 32'd8);
        lookup("mid_fade", 2'd3, 4'd7, 12'h730, 1'b0);
        start_fade(1'b1, 8'd1);
        chk("ignored_start_busy", 32'(fade_busy), 32'd1);
        ftick(2);
        chk("ignored_start_level", 32'(fade_level), 32'd7);
        ftick(13);
        chk("fo_level30t", 32'(fade_level), 32'd1);
        chk("fo_busy30t", 32'(fade_busy), 32'd1);
        ftick(1);
        chk("fo_level_end", 32'(fade_level), 32'd0);
        chk("fo_busy_end", 32'(fade_busy), 32'd0);
        lookup("black_idx2", 2'd2, 4'd2, 12'h000, 1'b0);
        lookup("black_key", 2'd2, 4'd0, 12'h000, 1'b1);

        // Fade out while already at 0: one step event, level unchanged
        start_fade(1'b0, 8'd0);
        chk("fo0_busy", 32'(fade_busy), 32'd1);
        ftick(1);
        chk("fo0_busy_end", 32'(fade_busy), 32'd0);
        chk("fo0_level", 32'(fade_level), 32'd0);

        // Fade in, step 0 (treated as 1)
        start_fade(1'b1, 8'd0);
        ftick(1);
        chk("fi_level1", 32'(fade_level), 32'd1);
        ftick(14);
        chk("fi_level15", 32'(fade_level), 32'd15);
        chk("fi_busy15", 32'(fade_busy), 32'd1);
        ftick(1);
        chk("fi_level16", 32'(fade_level), 32'd16);
        chk("fi_busy16", 32'(fade_busy), 32'd0);

        // Reset mid-fade after writes; write during reset is dropped
        wr(2'd0, 4'd4, 12'h123);
        start_fade(1'b0, 8'd1);
        ftick(3);
        chk("pre_rst_level", 32'(fade_level), 32'd13);
        reset        = 1'b1;
        wr_en        = 1'b1;
        wr_bank      = 2'd0;
        wr_index     = 4'd5;
        wr_data      = 12'h456;
        pix_valid_in = 1'b1;
        pix_bank     = 2'd0;
        pix_index    = 4'd4;
        tick();
        reset        = 1'b0;
        wr_en        = 1'b0;
        pix_valid_in = 1'b0;
        chk("mrst_level", 32'(fade_level), 32'd16);
        chk("mrst_busy", 32'(fade_busy), 32'd0);
        chk("mrst_vld", 32'(pix_valid_out), 32'd0);
        tick();
        chk("mrst_vld_next", 32'(pix_valid_out), 32'd0);
        lookup("mrst_default4", 2'd0, 4'd4, 12'hFFF, 1'b0);
        lookup("mrst_default5", 2'd0, 4'd5, 12'hFFF, 1'b0);
        lookup("mrst_bank1_3", 2'd1, 4'd3, 12'hFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
